// File: rtl/hex_timer_top.sv
// Free-running 24-hour HH:MM:SS clock: prescaler to a 1 Hz tick, cascaded BCD
// digit counters and six active-low seven-segment decoders.
`timescale 1ns/1ps

module hex_timer_top #(
    parameter int CLOCK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [6:0] o_HEX0,
    output logic [6:0] o_HEX1,
    output logic [6:0] o_HEX2,
    output logic [6:0] o_HEX3,
    output logic [6:0] o_HEX4,
    output logic [6:0] o_HEX5
);

    localparam int PW = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(CLOCK_FREQ - 1);

    logic [PW-1:0] prescaler;
    logic          tick;

    logic [3:0] s0, s1, m0, m1, h0, h1;
    logic       carry_s0, carry_s1, carry_m0, carry_m1;
    logic       last_hour;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    assign tick = (prescaler == PRESCALE_LAST);

    // Carries are combinational so a full rollover lands on one edge.
    assign carry_s0  = tick     && (s0 == 4'd9);
    assign carry_s1  = carry_s0 && (s1 == 4'd5);
    assign carry_m0  = carry_s1 && (m0 == 4'd9);
    assign carry_m1  = carry_m0 && (m1 == 4'd5);
    assign last_hour = (h1 == 4'd2) && (h0 == 4'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0 <= 4'd0;
            s1 <= 4'd0;
        end else begin
            if (tick) begin
                s0 <= carry_s0 ? 4'd0 : s0 + 4'd1;
            end
            if (carry_s0) begin
                s1 <= carry_s1 ? 4'd0 : s1 + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0 <= 4'd0;
            m1 <= 4'd0;
        end else begin
            if (carry_s1) begin
                m0 <= carry_m0 ? 4'd0 : m0 + 4'd1;
            end
            if (carry_m0) begin
                m1 <= carry_m1 ? 4'd0 : m1 + 4'd1;
            end
        end
    end

    // Hours wrap at 23 rather than at a digit boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h0 <= 4'd0;
            h1 <= 4'd0;
        end else if (carry_m1) begin
            if (last_hour) begin
                h0 <= 4'd0;
                h1 <= 4'd0;
            end else if (h0 == 4'd9) begin
                h0 <= 4'd0;
                h1 <= h1 + 4'd1;
            end else begin
                h0 <= h0 + 4'd1;
            end
        end
    end

    // Active-low segments, bit0 = a ... bit6 = g.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        seg = 7'h7F;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    assign o_HEX0 = seg_decode(s0);
    assign o_HEX1 = seg_decode(s1);
    assign o_HEX2 = seg_decode(m0);
    assign o_HEX3 = seg_decode(m1);
    assign o_HEX4 = seg_decode(h0);
    assign o_HEX5 = seg_decode(h1);

endmodule

// File: tb/tb_hex_timer_top.sv
// Bench for hex_timer_top: three instances (CLOCK_FREQ 50_000, 4, 2) on one clock,
// expected displays queued from a wall-clock model and popped after each step.
`timescale 1ns/1ps

module tb_hex_timer_top;

    logic clk;
    logic rst_a, rst_b, rst_c;
    logic [6:0] a0, a1, a2, a3, a4, a5;
    logic [6:0] b0, b1, b2, b3, b4, b5;
    logic [6:0] c0, c1, c2, c3, c4, c5;
    logic [41:0] disp_a, disp_b, disp_c;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [41:0] exp;
    } exp_t;
    exp_t sb[$];

    hex_timer_top #(.CLOCK_FREQ(50_000)) dut_a (
        .clk(clk), .rst_n(rst_a),
        .o_HEX0(a0), .o_HEX1(a1), .o_HEX2(a2), .o_HEX3(a3), .o_HEX4(a4), .o_HEX5(a5)
    );
    hex_timer_top #(.CLOCK_FREQ(4)) dut_b (
        .clk(clk), .rst_n(rst_b),
        .o_HEX0(b0), .o_HEX1(b1), .o_HEX2(b2), .o_HEX3(b3), .o_HEX4(b4), .o_HEX5(b5)
    );
    hex_timer_top #(.CLOCK_FREQ(2)) dut_c (
        .clk(clk), .rst_n(rst_c),
        .o_HEX0(c0), .o_HEX1(c1), .o_HEX2(c2), .o_HEX3(c3), .o_HEX4(c4), .o_HEX5(c5)
    );

    assign disp_a = {a5, a4, a3, a2, a1, a0};
    assign disp_b = {b5, b4, b3, b2, b1, b0};
    assign disp_c = {c5, c4, c3, c2, c1, c0};

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Display expected after a given number of ticks since reset, HEX5 in the top bits.
    function automatic logic [41:0] disp_of(input int ticks);
        int t, hh, mm, ss;
        t  = ticks % 86400;
        hh = t / 3600;
        mm = (t / 60) % 60;
        ss = t % 60;
        return {seg_of(hh / 10), seg_of(hh % 10), seg_of(mm / 10),
                seg_of(mm % 10), seg_of(ss / 10), seg_of(ss % 10)};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input int which);
        @(negedge clk);
        case (which)
            0: rst_a = 1'b0;
            1: rst_b = 1'b0;
            default: rst_c = 1'b0;
        endcase
        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;
    endtask

    // Loads dut_c with a given time of day, prescaler at zero, between edges.
    task automatic preload_c(input int ticks);
        int t, hh, mm, ss;
        t  = ticks % 86400;
        hh = t / 3600;
        mm = (t / 60) % 60;
        ss = t % 60;
        @(negedge clk);
        force dut_c.prescaler = '0;
        force dut_c.s0 = 4'(ss % 10);
        force dut_c.s1 = 4'(ss / 10);
        force dut_c.m0 = 4'(mm % 10);
        force dut_c.m1 = 4'(mm / 10);
        force dut_c.h0 = 4'(hh % 10);
        force dut_c.h1 = 4'(hh / 10);
        #1;
        release dut_c.prescaler;
        release dut_c.s0;
        release dut_c.s1;
        release dut_c.m0;
        release dut_c.m1;
        release dut_c.h0;
        release dut_c.h1;
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        @(negedge clk);
        rst_a = 1'b0;
        #0.5;
        sb.push_back('{"reset_hold", disp_of(0)});
        e = sb.pop_front();
        checks++;
        if (disp_a !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, disp_a, e.exp);
        end
        #0.5;
        rst_a = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            sb.push_back('{$sformatf("reset_idle_e%0d", n), disp_of(n / 50_000)});
            step(1);
            e = sb.pop_front();
            checks++;
            if (disp_a !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, disp_a, e.exp);
            end
        end
    endtask

    task automatic test_first_tick();
        exp_t e;
        pulse_reset(1);
        for (int n = 1; n <= 8; n++) begin
            sb.push_back('{$sformatf("first_tick_e%0d", n), disp_of(n / 4)});
            step(1);
            e = sb.pop_front();
            checks++;
            if (disp_b !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, disp_b, e.exp);
            end
        end
    endtask

    task automatic test_seconds_carry();
        exp_t e;
        pulse_reset(2);
        sb.push_back('{"sec_09", disp_of(9)});
        step(19);
        e = sb.pop_front();
        checks++;
        if (disp_c !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, disp_c, e.exp);
        end
        sb.push_back('{"sec_10", {35'(disp_of(10) >> 7), 7'h40}});
        step(1);
        e = sb.pop_front();
        checks++;
        if (disp_c !== e.exp || c1 !== 7'h79) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, disp_c, e.exp);
        end
    endtask

    task automatic test_minute_carry();
        exp_t e;
        pulse_reset(2);
        sb.push_back('{"min_0059", disp_of(59)});
        step(118);
        e = sb.pop_front();
        checks++;
        if (disp_c !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, disp_c, e.exp);
        end
        sb.push_back('{"min_0100", disp_of(60)});
        step(2);
        e = sb.pop_front();
        checks++;
        if (disp_c !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, disp_c, e.exp);
        end
    endtask

    task automatic test_hour_carry();
        exp_t e;
        int starts[2];
        starts[0] = 9 * 3600 + 3599;
        starts[1] = 19 * 3600 + 3599;
        for (int i = 0; i < 2; i++) begin
            preload_c(starts[i]);
            sb.push_back('{$sformatf("hour_pre_%0d", i), disp_of(starts[i])});
            e = sb.pop_front();
            checks++;
            if (disp_c !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, disp_c, e.exp);
            end
            sb.push_back('{$sformatf("hour_post_%0d", i), disp_of(starts[i] + 1)});
            step(2);
            e = sb.pop_front();
            checks++;
            if (disp_c !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, disp_c, e.exp);
            end
        end
    endtask

    task automatic test_day_rollover();
        exp_t e;
        preload_c(86399);
        sb.push_back('{"day_235959", {7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h10}});
        e = sb.pop_front();
        checks++;
        if (disp_c !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, disp_c, e.exp);
        end
        sb.push_back('{"day_hold", disp_of(86399)});
        step(1);
        e = sb.pop_front();
        checks++;
        if (disp_c !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, disp_c, e.exp);
        end
        sb.push_back('{"day_000000", {6{7'h40}}});
        step(1);
        e = sb.pop_front();
        checks++;
        if (disp_c !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, disp_c, e.exp);
        end
        sb.push_back('{"day_000001", disp_of(86401)});
        step(2);
        e = sb.pop_front();
        checks++;
        if (disp_c !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, disp_c, e.exp);
        end
    endtask

    task automatic test_midrun_reset();
        exp_t e;
        pulse_reset(1);
        sb.push_back('{"mid_0007", disp_of(7)});
        step(30);
        e = sb.pop_front();
        checks++;
        if (disp_b !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, disp_b, e.exp);
        end
        #3;
        rst_b = 1'b0;
        #1;
        sb.push_back('{"mid_async_clear", disp_of(0)});
        e = sb.pop_front();
        checks++;
        if (disp_b !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, disp_b, e.exp);
        end
        #1;
        rst_b = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            sb.push_back('{$sformatf("mid_after_e%0d", n), disp_of(n / 4)});
            step(1);
            e = sb.pop_front();
            checks++;
            if (disp_b !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, disp_b, e.exp);
            end
        end
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        #5;
        test_reset();
        test_first_tick();
        test_seconds_carry();
        test_minute_carry();
        test_hour_carry();
        test_day_rollover();
        test_midrun_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
